// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer: performs RV32I variable shifts (SLL/SRL/SRA) by
// driving a single-bit-shift ALU once per cycle. The ALU output is fed back
// as the next A operand until the shift amount is used up.
// Optional feature macro: SHIFT_SEQ_ABORT_EN (enables the abort input).
//
// state | meaning
// IDLE  | waiting for start; ALU held on pass-A
// SHIFT | one single-bit ALU shift per cycle, count decrementing
// DONE  | one-cycle completion; result and done valid together
module alu_shift_sequencer #(
   parameter int         n        = 32,
   parameter int         SHW      = 5,
   parameter logic [3:0] ALU_SLL  = 4'b1000,
   parameter logic [3:0] ALU_SRL  = 4'b0110,
   parameter logic [3:0] ALU_SRA  = 4'b0111,
   parameter logic [3:0] ALU_PASS = 4'b1111
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [n-1:0]   operand,
   input  logic [SHW-1:0] shamt,
   input  logic           abort,
   output logic [n-1:0]   alu_a,
   output logic [n-1:0]   alu_b,
   output logic [3:0]     alu_ctrl,
   input  logic [n-1:0]   alu_result,
   output logic           busy,
   output logic           done,
   output logic [n-1:0]   result
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t         state, state_nxt;
   logic [n-1:0]   acc, acc_nxt;
   logic [SHW-1:0] count, count_nxt;
   logic [1:0]     op_q, op_nxt;
   logic [3:0]     shift_code;
   logic           abort_hit;

`ifdef SHIFT_SEQ_ABORT_EN
   assign abort_hit = abort;
`else
   // Port kept for a uniform interface; the AND makes it a no-op.
   assign abort_hit = abort & 1'b0;
`endif

   // ALU code for the latched shift type; reserved op falls back to pass.
   always_comb begin
      shift_code = ALU_PASS;
      case (op_q)
         2'b00:   shift_code = ALU_SLL;
         2'b01:   shift_code = ALU_SRL;
         2'b10:   shift_code = ALU_SRA;
         default: shift_code = ALU_PASS;
      endcase
   end

   // Next-state, datapath update and ALU control.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      count_nxt = count;
      op_nxt    = op_q;
      alu_ctrl  = ALU_PASS;
      case (state)
         IDLE: begin
            if (start) begin
               acc_nxt   = operand;
               count_nxt = shamt;
               op_nxt    = op;
               state_nxt = (shamt != '0 && op != 2'b11) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            alu_ctrl = shift_code;
            acc_nxt  = alu_result;
            if (count != '0)
               count_nxt = count - SHW'(1);
            if (abort_hit)
               state_nxt = IDLE;
            else if (count == SHW'(1))
               state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, accumulator, count and latched op registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         op_q  <= 2'b00;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         count <= count_nxt;
         op_q  <= op_nxt;
      end
   end

   // Result captures the final accumulator on DONE entry so it rises with done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         result <= '0;
      else if (state_nxt == DONE && state != DONE)
         result <= acc_nxt;
   end

   assign alu_a = acc;
   assign alu_b = '0;
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);

endmodule
